// File: rtl/pwm_cycle_bank.sv
// pwm_cycle_bank: multi-channel LED brightness cycler.
// One shared PWM counter drives every channel, so all LEDs stay phase-aligned.
// Each channel has its own prescaler, which paces its brightness level.
// The 2-bit mode selects off, on, breathe (triangle) or blink (0/MAX toggle).
// Level, direction and prescaler state persist across mode changes; only reset clears them.
module pwm_cycle_bank #(
  parameter int CHANNELS = 3,
  parameter int SPEED_W  = 16,
  parameter int PWM_W    = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic [CHANNELS*SPEED_W-1:0]   speed,
  input  logic [CHANNELS*2-1:0]         mode,
  output logic [CHANNELS-1:0]           led,
  output logic                          pwm_wrap
);

  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_ON      = 2'b01,
    MODE_BREATHE = 2'b10,
    MODE_BLINK   = 2'b11
  } mode_e;

  localparam logic [PWM_W-1:0]   LVL_MAX  = '1;
  localparam logic [PWM_W-1:0]   LVL_ZERO = '0;
  localparam logic [PWM_W-1:0]   LVL_ONE  = {{(PWM_W-1){1'b0}}, 1'b1};
  localparam logic [SPEED_W-1:0] SPD_ZERO = '0;
  localparam logic [SPEED_W-1:0] SPD_ONE  = {{(SPEED_W-1){1'b0}}, 1'b1};

  // Per-channel views of the flat input buses.
  logic [CHANNELS-1:0][SPEED_W-1:0] speed_ch;
  logic [CHANNELS-1:0][1:0]         mode_ch;

  assign speed_ch = speed;
  assign mode_ch  = mode;

  logic [PWM_W-1:0]                 pwm_cnt_q, pwm_cnt_d;
  logic                             pwm_wrap_q, pwm_wrap_d;
  logic [CHANNELS-1:0]              led_q, led_d;
  logic [CHANNELS-1:0][SPEED_W-1:0] presc_q, presc_d;
  logic [CHANNELS-1:0][PWM_W-1:0]   level_q, level_d;
  // 1 = stepping down; meaningful only in breathe mode.
  logic [CHANNELS-1:0]              dir_down_q, dir_down_d;
  logic [CHANNELS-1:0]              tick;

  // Next-state logic for the shared counter, the prescalers, the levels and the outputs.
  always_comb begin
    pwm_cnt_d  = pwm_cnt_q + LVL_ONE;
    pwm_wrap_d = (pwm_cnt_q == LVL_MAX);
    presc_d    = presc_q;
    level_d    = level_q;
    dir_down_d = dir_down_q;
    tick       = '0;
    led_d      = '0;

    for (int i = 0; i < CHANNELS; i++) begin
      // A zero speed disables ticking entirely; the >= compare keeps a
      // speed reduction from overshooting the terminal count.
      if (enable) begin
        if (speed_ch[i] == SPD_ZERO) begin
          presc_d[i] = SPD_ZERO;
        end else if (presc_q[i] >= (speed_ch[i] - SPD_ONE)) begin
          presc_d[i] = SPD_ZERO;
          tick[i]    = 1'b1;
        end else begin
          presc_d[i] = presc_q[i] + SPD_ONE;
        end
      end

      if (tick[i]) begin
        case (mode_e'(mode_ch[i]))
          MODE_BREATHE: begin
            if (!dir_down_q[i]) begin
              // Level may already sit at MAX if blink left it there; turn around rather than wrap.
              if (level_q[i] == LVL_MAX) begin
                level_d[i]    = level_q[i] - LVL_ONE;
                dir_down_d[i] = 1'b1;
              end else begin
                level_d[i] = level_q[i] + LVL_ONE;
                if (level_q[i] + LVL_ONE == LVL_MAX) dir_down_d[i] = 1'b1;
              end
            end else begin
              if (level_q[i] == LVL_ZERO) begin
                level_d[i]    = level_q[i] + LVL_ONE;
                dir_down_d[i] = 1'b0;
              end else begin
                level_d[i] = level_q[i] - LVL_ONE;
                if (level_q[i] == LVL_ONE) dir_down_d[i] = 1'b0;
              end
            end
          end
          MODE_BLINK: begin
            level_d[i] = (level_q[i] != LVL_ZERO) ? LVL_ZERO : LVL_MAX;
          end
          default: begin
            level_d[i] = level_q[i];
          end
        endcase
      end

      case (mode_e'(mode_ch[i]))
        MODE_OFF: led_d[i] = 1'b0;
        MODE_ON:  led_d[i] = 1'b1;
        default:  led_d[i] = (pwm_cnt_q < level_q[i]);
      endcase
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pwm_cnt_q  <= '0;
      pwm_wrap_q <= 1'b0;
      led_q      <= '0;
      presc_q    <= '0;
      level_q    <= '0;
      dir_down_q <= '0;
    end else begin
      pwm_cnt_q  <= pwm_cnt_d;
      pwm_wrap_q <= pwm_wrap_d;
      led_q      <= led_d;
      presc_q    <= presc_d;
      level_q    <= level_d;
      dir_down_q <= dir_down_d;
    end
  end

  assign led      = led_q;
  assign pwm_wrap = pwm_wrap_q;

endmodule

// File: tb/tb_pwm_cycle_bank.sv
// Testbench for pwm_cycle_bank with 3 channels, 8-bit speeds and 4-bit PWM.
module tb_pwm_cycle_bank;

  localparam int CH  = 3;
  localparam int SW  = 8;
  localparam int PW  = 4;
  localparam int SPW = CH*SW;
  localparam int MDW = CH*2;

  logic           clk;
  logic           rst;
  logic           enable;
  logic [SPW-1:0] speed;
  logic [MDW-1:0] mode;
  logic [CH-1:0]  led;
  logic           pwm_wrap;

  int tests_run;
  int tests_failed;

  pwm_cycle_bank #(.CHANNELS(CH), .SPEED_W(SW), .PWM_W(PW)) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .speed    (speed),
    .mode     (mode),
    .led      (led),
    .pwm_wrap (pwm_wrap)
  );

  // Clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic           en;
    logic [MDW-1:0] md;
    logic [SPW-1:0] spd;
    int             cycles;
    int             exp_lvl0;
    int             exp_lvl1;
    int             exp_lvl2;
  } vec_t;

  vec_t vecs[6];

  // Advance one clock edge and settle just past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_levels(input string name, input int e0, input int e1, input int e2);
    check({name, " lvl0"}, int'(dut.level_q[0]), e0);
    check({name, " lvl1"}, int'(dut.level_q[1]), e1);
    check({name, " lvl2"}, int'(dut.level_q[2]), e2);
  endtask

  // Hold reset for three edges with random inputs, then release with the given settings.
  task automatic do_reset(input logic en, input logic [MDW-1:0] md, input logic [SPW-1:0] spd);
    rst    = 1'b0;
    enable = 1'($urandom_range(0, 1));
    speed  = SPW'($urandom);
    mode   = MDW'($urandom);
    repeat (3) step();
    enable = en;
    mode   = md;
    speed  = spd;
    rst    = 1'b1;
  endtask

  initial begin
    int cnt0, cnt1, cnt2;
    tests_run    = 0;
    tests_failed = 0;
    rst    = 1'b0;
    enable = 1'b0;
    speed  = '0;
    mode   = '0;

    // Reset state, then the first edge after release with modes off.
    do_reset(1'b1, 6'b000000, 24'd0);
    check("rst led", int'(led), 0);
    check("rst wrap", int'(pwm_wrap), 0);
    check_levels("rst", 0, 0, 0);
    step();
    check("post-rst led", int'(led), 0);
    check("post-rst wrap", int'(pwm_wrap), 0);
    check_levels("post-rst", 0, 0, 0);

    // Mode on: led constant 1; pwm_wrap every 16 edges; then mode off forces 0.
    do_reset(1'b1, 6'b010101, 24'd0);
    for (int k = 1; k <= 40; k++) begin
      step();
      check("on led", int'(led), 7);
      check("wrap", int'(pwm_wrap), (k % 16 == 0) ? 1 : 0);
    end
    mode = 6'b000000;
    for (int k = 0; k < 4; k++) begin
      step();
      check("off led", int'(led), 0);
    end

    // Table: sequential vectors from a fresh reset, levels checked after each.
    vecs[0] = '{1'b1, 6'b111010, {8'd4, 8'd3, 8'd2}, 12, 6, 4, 15};
    vecs[1] = '{1'b0, 6'b111010, {8'd4, 8'd3, 8'd2}, 20, 6, 4, 15};
    vecs[2] = '{1'b1, 6'b110100, {8'd4, 8'd3, 8'd2},  4, 6, 4, 0};
    vecs[3] = '{1'b1, 6'b101010, {8'd1, 8'd1, 8'd1}, 20, 4, 6, 10};
    vecs[4] = '{1'b1, 6'b111010, {8'd1, 8'd1, 8'd0},  3, 4, 3, 0};
    vecs[5] = '{1'b1, 6'b101010, {8'd0, 8'd0, 8'd0},  5, 4, 3, 0};
    do_reset(1'b1, 6'b000000, 24'd0);
    for (int v = 0; v < 6; v++) begin
      enable = vecs[v].en;
      mode   = vecs[v].md;
      speed  = vecs[v].spd;
      repeat (vecs[v].cycles) step();
      check_levels($sformatf("vec%0d", v), vecs[v].exp_lvl0, vecs[v].exp_lvl1, vecs[v].exp_lvl2);
    end

    // Breathe at speed 2: one step per 2 edges; then PWM duty at fixed levels.
    do_reset(1'b1, 6'b101010, {8'd0, 8'd0, 8'd2});
    for (int k = 1; k <= 10; k++) begin
      step();
      check($sformatf("breathe k%0d", k), int'(dut.level_q[0]), k / 2);
    end
    speed = {8'd1, 8'd0, 8'd0};
    repeat (15) step();
    speed = {8'd0, 8'd0, 8'd0};
    check_levels("duty setup", 5, 0, 15);
    cnt0 = 0;
    cnt1 = 0;
    cnt2 = 0;
    for (int k = 0; k < 16; k++) begin
      step();
      cnt0 += int'(led[0]);
      cnt1 += int'(led[1]);
      cnt2 += int'(led[2]);
    end
    check("duty lvl5", cnt0, 5);
    check("duty lvl0", cnt1, 0);
    check("duty lvl15", cnt2, 15);

    // Speed lowered mid-count: tick on the next edge, then every 10 edges.
    do_reset(1'b1, 6'b000010, {8'd0, 8'd0, 8'd100});
    repeat (50) step();
    check("slow presc lvl", int'(dut.level_q[0]), 0);
    speed = {8'd0, 8'd0, 8'd10};
    step();
    check("speed change tick", int'(dut.level_q[0]), 1);
    repeat (9) step();
    check("speed change hold", int'(dut.level_q[0]), 1);
    step();
    check("speed change next", int'(dut.level_q[0]), 2);

    // Reset mid-breathe while stepping down; direction must return to up.
    do_reset(1'b1, 6'b000010, {8'd0, 8'd0, 8'd1});
    repeat (17) step();
    check("pre-rst lvl", int'(dut.level_q[0]), 13);
    rst = 1'b0;
    step();
    check_levels("mid-rst", 0, 0, 0);
    check("mid-rst led", int'(led), 0);
    check("mid-rst wrap", int'(pwm_wrap), 0);
    rst = 1'b1;
    step();
    check("after mid-rst dir up", int'(dut.level_q[0]), 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
